// File: rtl/mem_access_stage_if.sv
// Execute -> memory -> write-back bus for mem_access_stage.
//   Upstream side (driven by the execute stage):
//     done_in, alu_result, store_data, mem_rd, mem_wr, wb_en, wb_reg, PC_in
//   Downstream side (driven by the memory stage):
//     busy, done_out, wb_data, wb_en_out, wb_reg_out, PC_out, misalign_err
// master: the agent that issues instructions and consumes results.
// slave : the memory stage itself.
interface mem_access_stage_if;
  logic        done_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_rd;
  logic        mem_wr;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] PC_in;

  logic        busy;
  logic        done_out;
  logic [31:0] wb_data;
  logic        wb_en_out;
  logic [4:0]  wb_reg_out;
  logic [31:0] PC_out;
  logic        misalign_err;

  modport master (
    output done_in, alu_result, store_data, mem_rd, mem_wr, wb_en, wb_reg, PC_in,
    input  busy, done_out, wb_data, wb_en_out, wb_reg_out, PC_out, misalign_err
  );

  modport slave (
    input  done_in, alu_result, store_data, mem_rd, mem_wr, wb_en, wb_reg, PC_in,
    output busy, done_out, wb_data, wb_en_out, wb_reg_out, PC_out, misalign_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory pipeline stage between execute and write-back.
// Non-memory instructions pass through in one cycle. Loads and stores
// access a local word-addressed memory (2**ADDR_W x 32) after WAIT_CYCLES
// wait states; upstream is stalled via busy while an access is in flight.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (memory contents are kept)
//   bus  : mem_access_stage_if.slave, see interface file for signal list
module mem_access_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  mem_access_stage_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // FSM and latched instruction
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          low_q, low_d;
  logic [31:0]         sdata_q, sdata_d;
  logic                is_st_q, is_st_d;
  logic                wben_q, wben_d;
  logic [4:0]          reg_q, reg_d;
  logic [31:0]         pc_q, pc_d;

  // registered outputs
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                wb_en_out_q, wb_en_out_d;
  logic [4:0]          wb_reg_out_q, wb_reg_out_d;
  logic [31:0]         pc_out_q, pc_out_d;
  logic                mis_q, mis_d;

  logic [31:0]         mem [2**ADDR_W];
  logic [31:0]         mem_rdata;
  logic                accept, accept_mem, complete, mem_we;

  // Address bits above ADDR_W+1 alias by design.
  logic                unused_hi;
  assign unused_hi = ^bus.alu_result[31:ADDR_W+2];

  assign accept     = (state_q == IDLE) && bus.done_in;
  assign accept_mem = accept && (bus.mem_rd || bus.mem_wr);
  assign complete   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign mem_rdata  = mem[addr_q];
  // rst gate: an access aborted by reset must not reach the array.
  assign mem_we     = !rst && complete && is_st_q && (low_q == 2'b00);

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      low_q        <= '0;
      sdata_q      <= '0;
      is_st_q      <= 1'b0;
      wben_q       <= 1'b0;
      reg_q        <= '0;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wb_data_q    <= '0;
      wb_en_out_q  <= 1'b0;
      wb_reg_out_q <= '0;
      pc_out_q     <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      low_q        <= low_d;
      sdata_q      <= sdata_d;
      is_st_q      <= is_st_d;
      wben_q       <= wben_d;
      reg_q        <= reg_d;
      pc_q         <= pc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wb_data_q    <= wb_data_d;
      wb_en_out_q  <= wb_en_out_d;
      wb_reg_out_q <= wb_reg_out_d;
      pc_out_q     <= pc_out_d;
      mis_q        <= mis_d;
    end
  end

  // Data array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= sdata_q;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    low_d   = low_q;
    sdata_d = sdata_q;
    is_st_d = is_st_q;
    wben_d  = wben_q;
    reg_d   = reg_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (accept_mem) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = bus.alu_result[ADDR_W+1:2];
          low_d   = bus.alu_result[1:0];
          sdata_d = bus.store_data;
          is_st_d = bus.mem_wr;      // rd+wr together behaves as a store
          wben_d  = bus.wb_en;
          reg_d   = bus.wb_reg;
          pc_d    = bus.PC_in;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy_d       = busy_q;
    done_d       = 1'b0;
    wb_data_d    = wb_data_q;
    wb_en_out_d  = wb_en_out_q;
    wb_reg_out_d = wb_reg_out_q;
    pc_out_d     = pc_out_q;
    mis_d        = mis_q;
    if (accept) begin
      if (accept_mem) begin
        busy_d = 1'b1;
      end else begin
        done_d       = 1'b1;
        wb_data_d    = bus.alu_result;
        wb_en_out_d  = bus.wb_en;
        wb_reg_out_d = bus.wb_reg;
        pc_out_d     = bus.PC_in;
        mis_d        = 1'b0;
      end
    end else if (complete) begin
      busy_d       = 1'b0;
      done_d       = 1'b1;
      wb_reg_out_d = reg_q;
      pc_out_d     = pc_q;
      mis_d        = (low_q != 2'b00);
      if (is_st_q) begin
        wb_en_out_d = 1'b0;
      end else begin
        // read-before-write: no write can coincide with a load completion
        wb_data_d   = (low_q != 2'b00) ? 32'h0 : mem_rdata;
        wb_en_out_d = wben_q;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done_out     = done_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_en_out    = wb_en_out_q;
  assign bus.wb_reg_out   = wb_reg_out_q;
  assign bus.PC_out       = pc_out_q;
  assign bus.misalign_err = mis_q;

endmodule
